// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, ALU-drive and response bundle of the sequencer.
// Signals: cmd_valid/ready/op/a/b, alu_a/b/sel/result, rsp_valid/ready/result/op,
//   op_count; rsp_div0 only when ALU_SEQ_DIV0_FLAG_EN is defined.
// master = sequencer side, slave = control/IO + ALU side.
interface alu_op_sequencer_if #(
    parameter int DW = 3,
    parameter int RW = 6
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_sel;
    logic [RW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_result;
    logic [1:0]    rsp_op;
    logic [7:0]    op_count;
`ifdef ALU_SEQ_DIV0_FLAG_EN
    logic          rsp_div0;
`endif

    modport master (
`ifdef ALU_SEQ_DIV0_FLAG_EN
        output rsp_div0,
`endif
        input  cmd_valid,
        output cmd_ready,
        input  cmd_op,
        input  cmd_a,
        input  cmd_b,
        output alu_a,
        output alu_b,
        output alu_sel,
        input  alu_result,
        output rsp_valid,
        input  rsp_ready,
        output rsp_result,
        output rsp_op,
        output op_count
    );

    modport slave (
`ifdef ALU_SEQ_DIV0_FLAG_EN
        input  rsp_div0,
`endif
        output cmd_valid,
        input  cmd_ready,
        output cmd_op,
        output cmd_a,
        output cmd_b,
        input  alu_a,
        input  alu_b,
        input  alu_sel,
        output alu_result,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_result,
        input  rsp_op,
        input  op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered issuer of (op, A, B) commands to the ALU,
// capturing each result after one settle cycle onto a valid/ready response.
// Ports: clk, rst_n (async, active low), bus (alu_op_sequencer_if.master).
// Option: define ALU_SEQ_DIV0_FLAG_EN to add the rsp_div0 response flag.
module alu_op_sequencer #(
    parameter int DW         = 3,
    parameter int RW         = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 2 + 2 * DW;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [1:0]    r_alu_sel;
    logic          r_rsp_valid;
    logic [RW-1:0] r_rsp_result;
    logic [1:0]    r_rsp_op;
    logic [7:0]    r_op_count;
`ifdef ALU_SEQ_DIV0_FLAG_EN
    logic          r_rsp_div0;
`endif

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    // Ready comes from registered occupancy only; a pop in the
    // same cycle does not open a slot early.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.cmd_valid & ~w_full;
    assign w_pop   = (r_state == S_IDLE) & ~w_empty;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_op     <= '0;
            r_op_count   <= '0;
`ifdef ALU_SEQ_DIV0_FLAG_EN
            r_rsp_div0   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_alu_sel, r_alu_a, r_alu_b} <= w_head;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // ALU inputs have been stable for a full cycle here.
                    r_rsp_result <= bus.alu_result;
                    r_rsp_op     <= r_alu_sel;
                    r_rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_DIV0_FLAG_EN
                    r_rsp_div0   <= (r_alu_sel == 2'b11) && (r_alu_b == '0);
`endif
                    r_state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
`ifdef ALU_SEQ_DIV0_FLAG_EN
                        r_rsp_div0  <= 1'b0;
`endif
                        r_op_count  <= r_op_count + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = ~w_full;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_sel    = r_alu_sel;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_op     = r_rsp_op;
    assign bus.op_count   = r_op_count;
`ifdef ALU_SEQ_DIV0_FLAG_EN
    assign bus.rsp_div0   = r_rsp_div0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + random bench for alu_op_sequencer,
// with a behavioural ALU and a timestamp-based transaction model.
module tb_alu_op_sequencer;
    localparam int DW    = 3;
    localparam int RW    = 6;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DW(DW), .RW(RW)) bus ();

    alu_op_sequencer #(
        .DW(DW), .RW(RW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic [RW-1:0] alu_fn(
        input logic [1:0] op,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            2'd0:    r = ia + ib;
            2'd1:    r = ia - ib;
            2'd2:    r = ia * ib;
            default: r = (ib == 0) ? 0 : ia / ib;
        endcase
        return RW'(r);
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            acc;
    } cmd_t;

    cmd_t pend[$];
    int   n;
    int   free_edge;
    int   completed;
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: check the state after edge n,
    // then drive inputs for edge n+1 and predict its effect.
    task automatic cycle(input logic v, input logic [1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic rr);
        int   pe;
        int   fcnt;
        logic popped;
        logic er;
        logic ev;
        pe     = 0;
        popped = 1'b0;
        if (pend.size() > 0) begin
            pe = (pend[0].acc + 1 > free_edge) ? pend[0].acc + 1 : free_edge;
            popped = (pe <= n);
        end
        fcnt = pend.size() - (popped ? 1 : 0);
        er   = (fcnt < DEPTH);
        ev   = popped && (n >= pe + 1);
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(er));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        chk("op_count", 32'(bus.op_count), 32'(completed % 256));
        if (popped) begin
            chk("alu_a", 32'(bus.alu_a), 32'(pend[0].a));
            chk("alu_b", 32'(bus.alu_b), 32'(pend[0].b));
            chk("alu_sel", 32'(bus.alu_sel), 32'(pend[0].op));
        end
        if (ev) begin
            chk("rsp_result", 32'(bus.rsp_result),
                32'(alu_fn(pend[0].op, pend[0].a, pend[0].b)));
            chk("rsp_op", 32'(bus.rsp_op), 32'(pend[0].op));
`ifdef ALU_SEQ_DIV0_FLAG_EN
            chk("rsp_div0", 32'(bus.rsp_div0),
                32'(pend[0].op == 2'b11 && pend[0].b == '0));
`endif
        end
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.rsp_ready = rr;
        if (ev && rr) begin
            void'(pend.pop_front());
            completed++;
            free_edge = n + 2;
        end
        if (v && er) begin
            pend.push_back('{op, a, b, n + 1});
        end
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic idle(input int k, input logic rr);
        for (int i = 0; i < k; i++) begin
            cycle(1'b0, 2'd0, '0, '0, rr);
        end
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
        chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
`ifdef ALU_SEQ_DIV0_FLAG_EN
        chk("rst_rsp_div0", 32'(bus.rsp_div0), 32'd0);
`endif
        pend.delete();
        n         = 0;
        free_edge = 1;
        completed = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();

        // add, then sub/mul in order
        cycle(1'b1, 2'd0, 3'd3, 3'd4, 1'b1);
        idle(4, 1'b1);
        cycle(1'b1, 2'd1, 3'd2, 3'd5, 1'b1);
        cycle(1'b1, 2'd2, 3'd7, 3'd7, 1'b1);
        idle(8, 1'b1);

        // divide, including by zero
        cycle(1'b1, 2'd3, 3'd5, 3'd0, 1'b1);
        cycle(1'b1, 2'd3, 3'd6, 3'd3, 1'b1);
        idle(8, 1'b1);

        // backpressure: six offers, five fit
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 2'(i), 3'(i + 1), 3'(7 - i), 1'b0);
        end
        chk("bp_queued", 32'(pend.size()), 32'd5);
        idle(5, 1'b0);
        idle(20, 1'b1);

        // reset while issuing with three queued
        cycle(1'b1, 2'd2, 3'd3, 3'd3, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'd0, 3'(i), 3'd1, 1'b0);
        end
        idle(1, 1'b1);
        idle(1, 1'b0);
        chk("pre_rst_queued", 32'(pend.size()), 32'd4);
        do_reset();
        idle(10, 1'b1);

        // random traffic until the counter wraps
        for (int i = 0; i < 6000 && completed < 256; i++) begin
            cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 8);
        end
        if (completed != 256) begin
            chk("wrap_budget", 32'(completed), 32'd256);
        end else begin
            chk("wrap", 32'(bus.op_count), 32'd0);
        end
        idle(10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
